// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for fifo_burst_reader: FIFO read side, burst request/abort
// and packed-burst output side.
interface fifo_burst_reader_if #(
    parameter int DataWidth = 4,
    parameter int BurstLen  = 4
);
    logic                          start_i;
    logic                          abort_i;
    logic                          rvalid_i;
    logic                          rready_o;
    logic [DataWidth-1:0]          data_i;
    logic                          valid_o;
    logic                          ready_i;
    logic [DataWidth*BurstLen-1:0] data_o;
    logic                          busy_o;
    logic                          done_o;

    // The reader itself
    modport slave (
        input  start_i, abort_i, rvalid_i, data_i, ready_i,
        output rready_o, valid_o, data_o, busy_o, done_o
    );

    // Whatever drives requests, feeds the FIFO and consumes bursts
    modport master (
        output start_i, abort_i, rvalid_i, data_i, ready_i,
        input  rready_o, valid_o, data_o, busy_o, done_o
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Collects BurstLen FIFO words into one packed word (word 0 in the LSBs) and
// offers it downstream with a valid/ready handshake.
module fifo_burst_reader #(
    parameter int DataWidth = 4,
    parameter int BurstLen  = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    fifo_burst_reader_if.slave  bus
);
    localparam int CntW = $clog2(BurstLen);
    localparam logic [CntW-1:0] LastCnt = CntW'(BurstLen - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] OUT     = 2'd2;

    logic [1:0]                    state;
    logic [CntW-1:0]               cnt;
    logic [DataWidth*BurstLen-1:0] data_q;
    logic                          done_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state <= COLLECT;
                        cnt   <= '0;
                    end
                end
                COLLECT: begin
                    // rready_o is high throughout COLLECT, so rvalid_i alone is a handshake
                    if (bus.abort_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (bus.rvalid_i) begin
                        for (int i = 0; i < BurstLen; i++) begin
                            if (cnt == CntW'(i)) begin
                                data_q[i*DataWidth +: DataWidth] <= bus.data_i;
                            end
                        end
                        if (cnt == LastCnt) begin
                            state <= OUT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CntW'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.ready_i) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // All handshake outputs decode from registered state only
    assign bus.rready_o = (state == COLLECT);
    assign bus.valid_o  = (state == OUT);
    assign bus.busy_o   = (state != IDLE);
    assign bus.done_o   = done_q;
    assign bus.data_o   = data_q;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue-backed FIFO source feeds
// words, expected packed bursts are queued at push time and popped on output.
module tb_fifo_burst_reader;
    localparam int DW = 4;
    localparam int BL = 4;

    logic clk;
    logic reset_i;

    fifo_burst_reader_if #(.DataWidth(DW), .BurstLen(BL)) bus ();

    fifo_burst_reader #(.DataWidth(DW), .BurstLen(BL)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]    src_q[$];
    logic [DW*BL-1:0] exp_q[$];
    int checks    = 0;
    int failures  = 0;
    int consumed  = 0;
    int bursts    = 0;
    int done_cnt  = 0;
    int cyc       = 0;
    bit gap_en    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        bus.rvalid_i = (src_q.size() > 0) && (!gap_en || (cyc % 3 == 0));
        bus.data_i   = (src_q.size() > 0) ? src_q[0] : '0;
    endtask

    task automatic push_burst(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                              input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        src_q.push_back(w0);
        src_q.push_back(w1);
        src_q.push_back(w2);
        src_q.push_back(w3);
        exp_q.push_back({w3, w2, w1, w0});
        drive_src();
    endtask

    // One clock: record handshakes seen at the edge, then score the results
    task automatic tick();
        logic hs, ohs;
        logic [DW*BL-1:0] od;
        hs  = bus.rvalid_i && bus.rready_o;
        ohs = bus.valid_o && bus.ready_i && !reset_i;
        od  = bus.data_o;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            if (src_q.size() > 0) src_q.delete(0);
            consumed++;
        end
        if (ohs) begin
            bursts++;
            if (exp_q.size() == 0) chk("unexpected_burst", 32'd1, 32'd0);
            else chk("burst_data", 32'(od), 32'(exp_q.pop_front()));
        end
        if (bus.done_o) done_cnt++;
        chk("done_pulse", 32'(bus.done_o), 32'(ohs));
        chk("rready_vs_valid", 32'(bus.rready_o & bus.valid_o), 32'd0);
        drive_src();
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int n = 0;
        while (!bus.done_o && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.done_o), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!bus.valid_o && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.valid_o), 32'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_data"},   32'(bus.data_o),   32'd0);
        chk({tag, "_valid"},  32'(bus.valid_o),  32'd0);
        chk({tag, "_rready"}, 32'(bus.rready_o), 32'd0);
        chk({tag, "_busy"},   32'(bus.busy_o),   32'd0);
        chk({tag, "_done"},   32'(bus.done_o),   32'd0);
    endtask

    task automatic flush();
        src_q.delete();
        exp_q.delete();
        drive_src();
    endtask

    initial begin
        int c0, b0, d0, n;
        reset_i     = 1'b1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.ready_i = 1'b0;
        drive_src();
        tick();
        tick();
        chk_reset("rst");
        reset_i = 1'b0;
        tick();

        // Back-to-back bursts, second start accepted in the done cycle
        c0 = consumed;
        d0 = done_cnt;
        bus.ready_i = 1'b1;
        push_burst(4'h1, 4'h2, 4'h3, 4'h4);
        pulse_start();
        repeat (3) tick();
        chk("t1_not_yet_valid", 32'(bus.valid_o), 32'd0);
        tick();
        chk("t1_valid", 32'(bus.valid_o), 32'd1);
        chk("t1_consumed", 32'(consumed - c0), 32'd4);
        push_burst(4'h8, 4'h4, 4'h2, 4'h1);
        tick();
        chk("t1_done_now", 32'(bus.done_o), 32'd1);
        pulse_start();
        chk("t1_b2b_busy", 32'(bus.busy_o), 32'd1);
        run_to_done("t1_done2", 40);
        tick();
        chk("t1_done_count", 32'(done_cnt - d0), 32'd2);
        chk("t1_consumed2", 32'(consumed - c0), 32'd8);

        // rvalid gaps
        c0 = consumed;
        gap_en = 1'b1;
        push_burst(4'h5, 4'h0, 4'hA, 4'hF);
        pulse_start();
        n = 0;
        while (!bus.valid_o && n < 100) begin
            chk("t2_rready_held", 32'(bus.rready_o), 32'd1);
            tick();
            n++;
        end
        chk("t2_valid", 32'(bus.valid_o), 32'd1);
        chk("t2_consumed", 32'(consumed - c0), 32'd4);
        run_to_done("t2_done", 10);
        gap_en = 1'b0;

        // Backpressure with an extra word waiting in the FIFO
        bus.ready_i = 1'b0;
        push_burst(4'h9, 4'h8, 4'h7, 4'h6);
        src_q.push_back(4'hC);
        drive_src();
        pulse_start();
        wait_valid("t3_valid", 40);
        c0 = consumed;
        repeat (5) begin
            tick();
            chk("t3_valid_held", 32'(bus.valid_o), 32'd1);
            chk("t3_data_held", 32'(bus.data_o), 32'h6789);
            chk("t3_rready_low", 32'(bus.rready_o), 32'd0);
            chk("t3_no_consume", 32'(consumed - c0), 32'd0);
        end
        bus.ready_i = 1'b1;
        tick();
        chk("t3_done", 32'(bus.done_o), 32'd1);
        flush();

        // Abort after two words; third word handshaken in the abort cycle
        c0 = consumed;
        b0 = bursts;
        d0 = done_cnt;
        src_q.push_back(4'h1);
        src_q.push_back(4'h2);
        src_q.push_back(4'h3);
        drive_src();
        pulse_start();
        n = 0;
        while ((consumed - c0) < 2 && n < 20) begin
            tick();
            n++;
        end
        chk("t4_two_words", 32'(consumed - c0), 32'd2);
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        chk("t4_busy", 32'(bus.busy_o), 32'd0);
        chk("t4_consumed", 32'(consumed - c0), 32'd3);
        repeat (3) begin
            tick();
            chk("t4_no_valid", 32'(bus.valid_o), 32'd0);
        end
        chk("t4_no_burst", 32'(bursts - b0), 32'd0);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
        push_burst(4'h7, 4'h7, 4'h7, 4'h7);
        pulse_start();
        run_to_done("t4_done", 40);

        // start_i held through COLLECT and OUT yields a single burst
        b0 = bursts;
        push_burst(4'hA, 4'hB, 4'hC, 4'hD);
        bus.start_i = 1'b1;
        wait_valid("t5_valid", 40);
        bus.start_i = 1'b0;
        repeat (4) tick();
        chk("t5_idle", 32'(bus.busy_o), 32'd0);
        chk("t5_one_burst", 32'(bursts - b0), 32'd1);

        // Reset mid-COLLECT, held for two cycles
        push_burst(4'h1, 4'h2, 4'h3, 4'h4);
        pulse_start();
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        chk_reset("t6_rst_collect");
        tick();
        chk_reset("t6_rst_held");
        flush();
        reset_i = 1'b0;
        tick();

        // Reset mid-OUT
        bus.ready_i = 1'b0;
        push_burst(4'h5, 4'h6, 4'h7, 4'h8);
        pulse_start();
        wait_valid("t6_valid", 40);
        reset_i = 1'b1;
        tick();
        chk_reset("t6_rst_out");
        flush();
        reset_i = 1'b0;
        tick();
        bus.ready_i = 1'b1;
        push_burst(4'hB, 4'hE, 4'hE, 4'hF);
        pulse_start();
        run_to_done("t6_done", 40);
        chk("t6_last_data", 32'(bus.data_o), 32'hFEEB);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DataWidth, default 4, meaning the FIFO word width in bits.
REQ-002 SHALL have parameter BurstLen, default 4, meaning the number of words per burst (>=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_i  input  1  burst request; sampled only in IDLE.
REQ-006 SHALL have port abort_i  input  1  cancels an in-progress collection.
REQ-007 SHALL have port rvalid_i  input  1  FIFO read side: word available.
REQ-008 SHALL have port rready_o  output  1  FIFO read side: reader accepts word.
REQ-009 SHALL have port data_i  input  DataWidth  FIFO read data.
REQ-010 SHALL have port valid_o  output  1  packed burst available downstream.
REQ-011 SHALL have port ready_i  input  1  downstream accepts packed burst.
REQ-012 SHALL have port data_o  output  DataWidth*BurstLen  packed burst, word 0 in LSBs.
REQ-013 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse after burst delivery.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT and OUT.
REQ-016 SHALL move IDLE->COLLECT on a clock edge where start_i=1, clearing the word counter to 0.
REQ-017 SHALL ignore start_i in COLLECT and OUT; no request is queued.
REQ-018 SHALL drive rready_o=1 only in COLLECT, decoded from state only, with no combinational path from any input.
REQ-019 SHALL capture data_i into data_o slot [cnt] and increment cnt on each cycle with rvalid_i=1 and rready_o=1.
REQ-020 SHALL hold state and cnt in COLLECT while rvalid_i=0; gaps of any length are legal.
REQ-021 SHALL move COLLECT->OUT on the handshake where cnt=BurstLen-1, leaving cnt at 0 and consuming exactly BurstLen words per burst.
REQ-022 SHALL drive valid_o=1 throughout OUT, with data_o stable while valid_o=1 and ready_i=0.
REQ-023 SHALL move OUT->IDLE on the edge where valid_o=1 and ready_i=1, and assert done_o for exactly the following cycle.
REQ-024 SHALL allow the next start_i to be accepted in the cycle done_o is high, since the FSM is then in IDLE.
REQ-025 SHALL move COLLECT->IDLE when abort_i=1, clearing cnt and raising no done_o; a word handshaken in that same cycle is consumed and discarded.
REQ-026 SHALL ignore abort_i in IDLE and OUT.
REQ-027 SHALL leave data_o holding the last captured words in IDLE; its value is only meaningful while valid_o=1.
REQ-028 SHALL use a counter of width clog2(BurstLen) with no wrap beyond BurstLen-1.

Reset
REQ-029 SHALL, with reset_i=1 at a rising edge, set the state to IDLE, cnt=0, data_o=0, valid_o=0, rready_o=0, busy_o=0 and done_o=0.
REQ-030 SHALL give reset priority over start_i, abort_i and all handshakes, including reset asserted mid-COLLECT or mid-OUT, which drops the partial or pending burst.
REQ-031 SHALL keep all outputs at their reset values while reset_i remains high.

Verification
REQ-032 SHALL cover back-to-back burst: start, rvalid_i=1 with data 1,2,3,4 and ready_i=1 -> valid_o after 4 handshakes, data_o=16'h4321, done_o pulses once.
REQ-033 SHALL cover rvalid gaps: words 5,0,A,F with idle cycles between them -> rready_o stays 1, data_o=16'hFA05, exactly 4 words consumed.
REQ-034 SHALL cover backpressure: ready_i=0 for 5 cycles in OUT -> valid_o=1 and data_o constant, rready_o=0, and no FIFO word consumed.
REQ-035 SHALL cover abort after 2 words -> IDLE, busy_o=0, no valid_o or done_o; the next burst of 7,7,7,7 gives data_o=16'h7777.
REQ-036 SHALL cover start_i=1 held during COLLECT/OUT -> exactly one burst; a new burst starts only if start_i=1 in IDLE.
REQ-037 SHALL cover reset asserted mid-COLLECT and mid-OUT -> all outputs at reset values next cycle and a subsequent burst correct.
